// File: rtl/fp16_mul_stage.sv
// FP16 multiplier stage: 2-cycle pipelined product feeding a dot-product accumulator.
// Subnormals flush to zero, Inf/NaN saturate to max finite, truncation rounding.
module fp16_mul_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      in_act,
  input  logic [15:0]      in_wgt,
  input  logic             in_valid,
  input  logic             in_last,
  output logic [15:0]      prod,
  output logic             prod_valid,
  output logic             prod_last,
  output logic [CNT_W-1:0] elem_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [4:0]        a_exp;
  logic [4:0]        w_exp;
  logic signed [6:0] exp_sum;
  logic [21:0]       man_prod;

  logic              s1_sign;
  logic signed [6:0] s1_exp;
  logic [21:0]       s1_man;
  logic              s1_zero;
  logic              s1_sat;
  logic              s1_valid;
  logic              s1_last;

  logic signed [6:0] exp_n;
  logic [9:0]        frac_n;
  logic [15:0]       res;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_base;

  always_comb begin
    a_exp    = in_act[14:10];
    w_exp    = in_wgt[14:10];
    exp_sum  = $signed({2'b00, a_exp})
             + $signed({2'b00, w_exp})
             - 7'sd15;
    man_prod = {11'd0, 1'b1, in_act[9:0]}
             * {11'd0, 1'b1, in_wgt[9:0]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_man   <= '0;
      s1_zero  <= 1'b0;
      s1_sat   <= 1'b0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_sign  <= in_act[15] ^ in_wgt[15];
      s1_exp   <= exp_sum;
      s1_man   <= man_prod;
      s1_zero  <= (a_exp == 5'd0) || (w_exp == 5'd0);
      s1_sat   <= (a_exp == 5'd31) || (w_exp == 5'd31);
      s1_valid <= in_valid;
      s1_last  <= in_valid & in_last;
    end
  end

  // Mantissa product lies in [1,4); a set top bit means one right shift.
  always_comb begin
    exp_n  = s1_exp + $signed({6'd0, s1_man[21]});
    frac_n = s1_man[21] ? s1_man[20:11] : s1_man[19:10];
    if (s1_zero)
      res = 16'h0000;
    else if (s1_sat || (exp_n > 7'sd30))
      res = {s1_sign, 15'h7BFF};
    else if (exp_n < 7'sd1)
      res = 16'h0000;
    else
      res = {s1_sign, exp_n[4:0], frac_n};
  end

  // A completed dot product restarts the count on the following cycle.
  always_comb begin
    cnt_base = prod_last ? '0 : cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod       <= 16'h0000;
      prod_valid <= 1'b0;
      prod_last  <= 1'b0;
      cnt        <= '0;
    end else begin
      prod       <= s1_valid ? res : 16'h0000;
      prod_valid <= s1_valid;
      prod_last  <= s1_valid & s1_last;
      if (s1_valid)
        cnt <= (cnt_base == CNT_MAX) ? cnt_base : cnt_base + 1'b1;
      else
        cnt <= cnt_base;
    end
  end

  assign elem_cnt = cnt;

endmodule

// File: tb/tb_fp16_mul_stage.sv
// Scoreboard bench for fp16_mul_stage: reference model on integer arithmetic,
// directed special values plus randomized streams, resets and saturation.
module tb_fp16_mul_stage;

  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   in_act;
  logic [15:0]   in_wgt;
  logic          in_valid;
  logic          in_last;
  logic [15:0]   prod;
  logic          prod_valid;
  logic          prod_last;
  logic [CW-1:0] elem_cnt;

  fp16_mul_stage #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_act     (in_act),
    .in_wgt     (in_wgt),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .prod       (prod),
    .prod_valid (prod_valid),
    .prod_last  (prod_last),
    .elem_cnt   (elem_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]   p;
    logic          l;
    logic [CW-1:0] c;
    int            due;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  logic mon_en = 1'b0;
  logic rst_q = 1'b0;

  logic [CW-1:0] s_cnt = '0;
  logic          s_prev_last = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, e, f;
    longint m;
    logic s;
    logic [15:0] r;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    s  = a[15] ^ b[15];
    if (ea == 0 || eb == 0) return 16'h0000;
    if (ea == 31 || eb == 31) return {s, 15'h7BFF};
    m = longint'(1024 + int'(a[9:0])) * longint'(1024 + int'(b[9:0]));
    e = ea + eb - 15;
    while (m >= 64'd2097152) begin
      m = m / 2;
      e = e + 1;
    end
    f = int'((m / 1024) % 1024);
    if (e > 30) return {s, 15'h7BFF};
    if (e < 1) return 16'h0000;
    r = {s, 5'(e), 10'(f)};
    return r;
  endfunction

  function automatic logic [15:0] rand_op();
    logic [4:0] e;
    logic [9:0] f;
    logic s;
    s = 1'($urandom);
    f = 10'($urandom);
    case ($urandom % 8)
      0: e = 5'd0;
      1: e = 5'd31;
      2: e = 5'($urandom_range(1, 8));
      3: e = 5'($urandom_range(22, 30));
      default: e = 5'($urandom_range(1, 30));
    endcase
    return {s, e, f};
  endfunction

  task automatic issue(input logic [15:0] a, input logic [15:0] w,
                       input logic v, input logic l);
    exp_t x;
    in_act   = a;
    in_wgt   = w;
    in_valid = v;
    in_last  = l;
    if (v) begin
      s_cnt = s_prev_last ? CW'(1) : ((s_cnt == CMAX) ? CMAX : s_cnt + 1'b1);
      s_prev_last = l;
      x.p = ref_mul(a, w);
      x.l = l;
      x.c = s_cnt;
      x.due = cyc + 2;
      q.push_back(x);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b1;
    while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
    s_cnt = '0;
    s_prev_last = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    rst_n   = 1'b1;
    in_last = 1'b0;
  endtask

  logic [CW-1:0] h_cnt = '0;
  logic          h_last = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t x;
      if (!rst_q) begin
        h_cnt  = '0;
        h_last = 1'b0;
      end
      while (q.size() > 0 && q[0].due < cyc) begin
        n_vec++;
        n_bad++;
        $display("FAIL lost_product due=%0d now=%0d want prod=%h", q[0].due, cyc, q[0].p);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        x = q.pop_front();
        n_vec++;
        if (prod_valid !== 1'b1 || prod !== x.p || prod_last !== x.l || elem_cnt !== x.c) begin
          n_bad++;
          $display("FAIL product cyc=%0d got v=%b p=%h l=%b c=%0d want v=1 p=%h l=%b c=%0d",
                   cyc, prod_valid, prod, prod_last, elem_cnt, x.p, x.l, x.c);
        end
        h_cnt  = x.c;
        h_last = x.l;
      end else begin
        if (h_last) begin
          h_cnt  = '0;
          h_last = 1'b0;
        end
        n_vec++;
        if (prod_valid !== 1'b0 || prod !== 16'h0000 || prod_last !== 1'b0 || elem_cnt !== h_cnt) begin
          n_bad++;
          $display("FAIL idle cyc=%0d got v=%b p=%h l=%b c=%0d want v=0 p=0000 l=0 c=%0d",
                   cyc, prod_valid, prod, prod_last, elem_cnt, h_cnt);
        end
      end
    end
  end

  logic [15:0] da [8] = '{16'h3C00, 16'h3E00, 16'hBC00, 16'h7BFF,
                          16'hFC00, 16'h0000, 16'h0400, 16'h3C00};
  logic [15:0] dw [8] = '{16'h4000, 16'h3E00, 16'h4000, 16'h7BFF,
                          16'h3C00, 16'h5000, 16'h0400, 16'h3C00};

  initial begin
    rst_n    = 1'b0;
    in_act   = '0;
    in_wgt   = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    do_reset(3);
    issue(16'h0, 16'h0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) issue(da[i], dw[i], 1'b1, 1'b1);
    issue(16'h0, 16'h0, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++) issue(rand_op(), rand_op(), 1'b1, i == 3);
    issue(rand_op(), rand_op(), 1'b1, 1'b0);
    issue(rand_op(), rand_op(), 1'b1, 1'b0);
    issue(16'h0, 16'h0, 1'b0, 1'b0);
    issue(16'h0, 16'h0, 1'b0, 1'b0);
    issue(rand_op(), rand_op(), 1'b1, 1'b1);

    for (int i = 0; i < 300; i++) begin
      logic v;
      v = ($urandom % 10) < 8;
      issue(rand_op(), rand_op(), v, ($urandom % 5) == 0);
    end

    for (int i = 0; i < 20; i++) issue(rand_op(), rand_op(), 1'b1, 1'b0);
    issue(16'h3C00, 16'h3C00, 1'b1, 1'b1);

    issue(rand_op(), rand_op(), 1'b1, 1'b0);
    issue(rand_op(), rand_op(), 1'b1, 1'b0);
    do_reset(1);
    issue(16'h0, 16'h0, 1'b0, 1'b0);
    issue(16'h0, 16'h0, 1'b0, 1'b0);
    issue(16'h4000, 16'h4200, 1'b1, 1'b1);

    for (int i = 0; i < 100; i++) begin
      if (i == 50) do_reset(2);
      issue(rand_op(), rand_op(), 1'b1, ($urandom % 6) == 0);
    end

    repeat (5) issue(16'h0, 16'h0, 1'b0, 1'b0);
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fp16_mul_stage.md
FP16_MUL_STAGE -- requirements
Module: fp16_mul_stage

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 16, width of the product counter.
REQ-002 The block SHALL have the following ports, in this order:
  clk  input  1  single clock; all state updates on its rising edge
  rst_n  input  1  reset; synchronous, active-low
  in_act  input  16  FP16 activation operand
  in_wgt  input  16  FP16 weight operand
  in_valid  input  1  operand pair valid this cycle
  in_last  input  1  final pair of the current dot product; qualified by in_valid
  prod  output  16  FP16 product; feeds the accumulator data input
  prod_valid  output  1  prod valid this cycle
  prod_last  output  1  final product of the dot product; drives the accumulator's accum-done input
  elem_cnt  output  CNT_W  count of valid products emitted in the current dot product, including this cycle's

Function
REQ-003 The pipeline SHALL be 2 stages: an operand pair accepted in cycle N SHALL appear on prod/prod_valid/prod_last in cycle N+2.
REQ-004 The pipeline SHALL have no backpressure and SHALL accept one pair per cycle with no bubbles.
REQ-005 Stage 1 SHALL register the following:
  - sign = act[15] XOR wgt[15]
  - 7-bit signed exponent sum = act_exp + wgt_exp - 15
  - 22-bit mantissa product {1,act[9:0]} x {1,wgt[9:0]}
  - zero flag, sat flag, valid, last
REQ-006 If either operand exponent is 0, the zero flag SHALL be set; subnormal inputs flush to zero.
REQ-007 If either operand exponent is 31, the sat flag SHALL be set; Inf and NaN are treated as overflow.
REQ-008 Stage 2 SHALL normalize the product:
  - if product[21]=1: exp+1, frac = product[20:11]
  - else: frac = product[19:10]
  - rounding is truncation only
REQ-009 Result selection SHALL be applied in the following priority:
  - zero flag: prod = 16'h0000
  - sat flag, or final exp > 30: prod = {sign, 15'h7BFF}
  - final exp < 1: prod = 16'h0000
  - otherwise: prod = {sign, exp[4:0], frac}
REQ-010 When prod_valid=0, prod SHALL be 16'h0000 and prod_last SHALL be 0.
REQ-011 in_last SHALL be ignored when in_valid=0.
REQ-012 prod_last SHALL equal the in_last value delayed 2 cycles and AND-ed with the delayed valid.
REQ-013 The counter SHALL increment by 1 on each cycle with prod_valid=1, and elem_cnt SHALL present the updated value in that same cycle.
REQ-014 The counter SHALL clear to 0 in the cycle after prod_last=1, so the next dot product starts at 1.
REQ-015 The counter SHALL saturate at 2^CNT_W-1 and SHALL not wrap.
REQ-016 elem_cnt SHALL hold its value when prod_valid=0.
REQ-017 Back-to-back dot products (in_last in cycle N, new pair in cycle N+1) SHALL keep both products and their counts separate, with no lost or merged elements.
REQ-018 All arithmetic intermediates SHALL be wide enough that no wrap occurs: exponent sum range -15..47 fits in 7 bits signed.

Reset
REQ-019 When rst_n=0 at a rising clk edge, all pipeline registers SHALL clear, including valid, last and the flags.
REQ-020 During and after reset, prod=16'h0000, prod_valid=0, prod_last=0 and elem_cnt=0.
REQ-021 Reset asserted mid-operation SHALL discard in-flight products, so no prod_valid appears from pre-reset inputs.
REQ-022 The first pair accepted after rst_n returns high SHALL emerge 2 cycles later with elem_cnt=1.

Verification
REQ-023 Basic product: act=3C00, wgt=4000, valid=1 in cycle 0 -> cycle 2: prod=4000, prod_valid=1, elem_cnt=1.
REQ-024 Normalize carry: 3E00 x 3E00 -> prod=4080 (2.25).
REQ-025 Sign handling: BC00 x 4000 -> prod=C000.
REQ-026 Special values:
  - 7BFF x 7BFF -> 7BFF
  - FC00 x 3C00 -> FBFF
  - 0000 x 5000 -> 0000
  - 0400 x 0400 -> 0000 (underflow)
REQ-027 Stream of 4 pairs with in_last on the 4th, followed immediately by 2 more pairs:
  - elem_cnt sequence 1,2,3,4 with prod_last only on 4
  - then 1,2 for the next dot product
  - a gap cycle with valid=0 holds elem_cnt and gives prod=0000
REQ-028 Reset mid-stream: rst_n low for 1 cycle while 2 products are in flight -> no prod_valid in the next 2 cycles and elem_cnt=0.
